// File: rtl/axi_lite_m.sv
// Single-outstanding AXI4-Lite master: turns one core-side read/write request
// into the matching AXI-Lite channel handshakes and returns a one-cycle response.
module axi_lite_m (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW_W = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = req_we ? S_AW_W : S_AR;
                end
            end
            S_AR: begin
                if (arready) state_d = S_AR + 3'd1;
            end
            S_R: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = (rresp != 2'b00);
                    state_d = S_RESP;
                end
            end
            S_AW_W: begin
                // A ready seen after its own handshake is harmless: the flag is already set.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Every output is a register or a decode of state, never a slave input.
    assign req_ready  = (state_q == S_IDLE);
    assign arvalid    = (state_q == S_AR);
    assign araddr     = addr_q;
    assign rready     = (state_q == S_R);
    assign awvalid    = (state_q == S_AW_W) && !aw_done_q;
    assign awaddr     = addr_q;
    assign wvalid     = (state_q == S_AW_W) && !w_done_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign bready     = (state_q == S_B);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_axi_lite_m.sv
// Directed bench for axi_lite_m: a delay-programmable AXI-Lite slave plus
// per-scenario tasks with hand-computed expectations.
module tb_axi_lite_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [31:0] araddr, awaddr;
    logic        arvalid, arready = 1'b0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready;

    axi_lite_m dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model: each ready/valid answers after a programmable number of waiting cycles.
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    logic [63:0] rdata_v = '0;
    logic [1:0]  rresp_v = '0, bresp_v = '0;
    logic        spur_r = 1'b0, spur_b = 1'b0;

    always @(negedge clk) begin
        arready = arvalid && (ar_c == ar_dly);
        if (arvalid && ar_c != ar_dly) ar_c++; else ar_c = 0;
        rvalid = spur_r || (rready && r_c == r_dly);
        rdata  = rdata_v;
        rresp  = rresp_v;
        if (rready && r_c != r_dly) r_c++; else r_c = 0;
        awready = awvalid && (aw_c == aw_dly);
        if (awvalid && aw_c != aw_dly) aw_c++; else aw_c = 0;
        wready = wvalid && (w_c == w_dly);
        if (wvalid && w_c != w_dly) w_c++; else w_c = 0;
        bvalid = spur_b || (bready && b_c == b_dly);
        bresp  = bresp_v;
        if (bready && b_c != b_dly) b_c++; else b_c = 0;
    end

    // Per-transaction observations gathered by run_txn.
    int lat, pulses, rdy_bad, ar_unstable, ar_hs, arv_cyc, aw_hs, aw_cyc, aw_after;
    int w_hs, w_cyc, wv_cyc, b_hs;
    logic        ar_seen, aw_seen, idle_after, er;
    logic [63:0] rd, wdata_s;
    logic [31:0] ar_addr, awaddr_s;
    logic [7:0]  wstrb_s;

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s);
        int k;
        lat = -1; pulses = 0; rdy_bad = 0; ar_unstable = 0; ar_hs = 0; arv_cyc = 0;
        aw_hs = 0; aw_cyc = -1; aw_after = 0; w_hs = 0; w_cyc = -1; wv_cyc = 0; b_hs = 0;
        ar_seen = 0; aw_seen = 0; idle_after = 0; er = 0; rd = '0;
        ar_addr = '0; awaddr_s = '0; wdata_s = '0; wstrb_s = '0;
        step();
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        k = 0;
        while (!req_ready && k < 20) begin
            step();
            k++;
        end
        for (k = 1; k <= 40; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            if (resp_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rd = resp_rdata; er = resp_err;
                end
            end
            if (lat < 0 && req_ready) rdy_bad++;
            if (arvalid) begin
                arv_cyc++;
                if (!ar_seen) begin
                    ar_seen = 1; ar_addr = araddr;
                end else if (araddr !== ar_addr) ar_unstable++;
                if (arready) ar_hs++;
            end
            if (awvalid) begin
                if (aw_hs > 0) aw_after++;
                if (!aw_seen) begin
                    aw_seen = 1; awaddr_s = awaddr;
                end
                if (awready) begin
                    aw_hs++; aw_cyc = k;
                end
            end
            if (wvalid) begin
                wv_cyc++; wdata_s = wdata; wstrb_s = wstrb;
                if (wready) begin
                    w_hs++; w_cyc = k;
                end
            end
            if (bvalid && bready) b_hs++;
            if (lat >= 0 && k == lat + 1) begin
                idle_after = req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err});
        end
        checks++;
        if ({araddr, awaddr, wstrb} !== 72'h0 || wdata !== 64'h0 || resp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h %h want all zero",
                     araddr, awaddr, wdata, wstrb, resp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        ar_dly = 0; r_dly = 0; rdata_v = 64'h1122334455667788; rresp_v = 2'b00;
        run_txn(1'b0, 32'h80000000, 64'h0, 8'h00);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd0_latency got %0d want 3", lat); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL rd0_pulses got %0d want 1", pulses); end
        checks++;
        if (rd !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd0_rdata got %h want 1122334455667788", rd);
        end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL rd0_err got %b want 0", er); end
        checks++;
        if (ar_addr !== 32'h80000000 || ar_hs !== 1) begin
            errors++; $display("FAIL rd0_ar got %h/%0d want 80000000/1", ar_addr, ar_hs);
        end
        checks++;
        if (idle_after !== 1'b1) begin errors++; $display("FAIL rd0_idle got %b want 1", idle_after); end
    endtask

    task automatic test_write_skew();
        aw_dly = 0; w_dly = 2; b_dly = 0; bresp_v = 2'b00;
        run_txn(1'b1, 32'h80000010, 64'hDEADBEEF, 8'h0F);
        checks++;
        if (aw_cyc !== 1 || aw_hs !== 1 || aw_after !== 0) begin
            errors++;
            $display("FAIL wr_aw got cyc%0d hs%0d after%0d want cyc1 hs1 after0", aw_cyc, aw_hs, aw_after);
        end
        checks++;
        if (w_cyc !== 3 || w_hs !== 1 || wv_cyc !== 3) begin
            errors++;
            $display("FAIL wr_w got cyc%0d hs%0d vcyc%0d want cyc3 hs1 vcyc3", w_cyc, w_hs, wv_cyc);
        end
        checks++;
        if (awaddr_s !== 32'h80000010 || wdata_s !== 64'hDEADBEEF || wstrb_s !== 8'h0F) begin
            errors++;
            $display("FAIL wr_payload got %h %h %h want 80000010 00000000deadbeef 0f",
                     awaddr_s, wdata_s, wstrb_s);
        end
        checks++;
        if (b_hs !== 1 || lat !== 5 || pulses !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got b%0d lat%0d p%0d err%b want b1 lat5 p1 err0", b_hs, lat, pulses, er);
        end
        checks++;
        if (rd !== 64'h1122334455667788) begin
            errors++; $display("FAIL wr_rdata_kept got %h want 1122334455667788", rd);
        end
        w_dly = 0;
    endtask

    task automatic test_read_delayed();
        ar_dly = 3; r_dly = 2; rdata_v = 64'h0123456789ABCDEF; rresp_v = 2'b00;
        run_txn(1'b0, 32'h40001234, 64'h0, 8'h00);
        checks++;
        if (lat !== 8 || pulses !== 1) begin
            errors++; $display("FAIL rdd_latency got lat%0d p%0d want lat8 p1", lat, pulses);
        end
        checks++;
        if (ar_unstable !== 0 || arv_cyc !== 4 || ar_addr !== 32'h40001234 || ar_hs !== 1) begin
            errors++;
            $display("FAIL rdd_ar got unst%0d cyc%0d %h hs%0d want 0 4 40001234 1",
                     ar_unstable, arv_cyc, ar_addr, ar_hs);
        end
        checks++;
        if (rdy_bad !== 0) begin errors++; $display("FAIL rdd_ready got %0d want 0", rdy_bad); end
        checks++;
        if (rd !== 64'h0123456789ABCDEF) begin
            errors++; $display("FAIL rdd_rdata got %h want 0123456789abcdef", rd);
        end
        ar_dly = 0; r_dly = 0;
    endtask

    task automatic test_errors();
        rdata_v = 64'hA5A5A5A55A5A5A5A; rresp_v = 2'b11;
        run_txn(1'b0, 32'h00000100, 64'h0, 8'h00);
        checks++;
        if (er !== 1'b1 || rd !== 64'hA5A5A5A55A5A5A5A || lat !== 3 || idle_after !== 1'b1) begin
            errors++;
            $display("FAIL rd_err got err%b %h lat%0d idle%b want 1 a5a5a5a55a5a5a5a 3 1",
                     er, rd, lat, idle_after);
        end
        rresp_v = 2'b00; bresp_v = 2'b10;
        run_txn(1'b1, 32'h00000200, 64'h55, 8'hFF);
        checks++;
        if (er !== 1'b1 || rd !== 64'hA5A5A5A55A5A5A5A || lat !== 3 || idle_after !== 1'b1) begin
            errors++;
            $display("FAIL wr_err got err%b %h lat%0d idle%b want 1 a5a5a5a55a5a5a5a 3 1",
                     er, rd, lat, idle_after);
        end
        bresp_v = 2'b00;
        run_txn(1'b1, 32'h00000200, 64'h55, 8'hFF);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL wr_ok_clears_err got %b want 0", er); end
    endtask

    task automatic test_spurious();
        spur_r = 1'b1; spur_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({req_ready, resp_valid, rready, bready} !== 4'b1000) begin
                errors++;
                $display("FAIL spurious got %b want 1000", {req_ready, resp_valid, rready, bready});
            end
        end
        spur_r = 1'b0; spur_b = 1'b0;
    endtask

    task automatic test_reset_mid_r();
        int k;
        logic bad;
        r_dly = 10; rdata_v = 64'h0F0F0F0F0F0F0F0F;
        step();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00000300;
        step();
        req_valid = 1'b0;
        k = 0;
        while (!rready && k < 10) begin
            step();
            k++;
        end
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL rst_r_reach got %b want 1", rready); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({rready, arvalid, resp_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_r_async got %b want 0001", {rready, arvalid, resp_valid, req_ready});
        end
        step();
        rst = 1'b0;
        r_dly = 0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if ({resp_valid, arvalid, rready, awvalid, wvalid, bready} !== 6'b0 || !req_ready) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rst_r_residual got %b want 0", bad); end
        run_txn(1'b0, 32'h00000400, 64'h0, 8'h00);
        checks++;
        if (lat !== 3 || rd !== 64'h0F0F0F0F0F0F0F0F || er !== 1'b0) begin
            errors++;
            $display("FAIL rst_r_next got lat%0d %h err%b want 3 0f0f0f0f0f0f0f0f 0", lat, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2, acc2, ar1, ar2, npulse;
        logic [31:0] a1, a2;
        r1 = -1; r2 = -1; acc2 = -1; ar1 = -1; ar2 = -1; npulse = 0; a1 = '0; a2 = '0;
        rdata_v = 64'hCAFEF00D12345678;
        step();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00001000;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) req_addr = 32'h00002000;
            if (acc2 >= 0 && k == acc2 + 1) req_valid = 1'b0;
            if (resp_valid) begin
                npulse++;
                if (r1 < 0) r1 = k; else r2 = k;
            end
            if (r1 >= 0 && acc2 < 0 && req_ready) acc2 = k;
            if (arvalid && arready) begin
                if (ar1 < 0) begin ar1 = k; a1 = araddr; end
                else begin ar2 = k; a2 = araddr; end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (r1 !== 3 || acc2 !== 4 || r2 !== 7 || npulse !== 2) begin
            errors++;
            $display("FAIL b2b_timing got r1=%0d acc2=%0d r2=%0d n=%0d want 3 4 7 2", r1, acc2, r2, npulse);
        end
        checks++;
        if (ar1 !== 1 || ar2 !== 5 || a1 !== 32'h00001000 || a2 !== 32'h00002000) begin
            errors++;
            $display("FAIL b2b_ar got %0d %0d %h %h want 1 5 00001000 00002000", ar1, ar2, a1, a2);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_skew();
        test_read_delayed();
        test_errors();
        test_spurious();
        test_reset_mid_r();
        test_back_to_back();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_m.md
AXI_LITE_M -- requirements
Module: axi_lite_m

Interface
REQ-001 Parameters: none; all widths are fixed (address 32, data 64, strobe 8).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  core-side request present.
REQ-005 req_ready  out  1  block idle and able to accept a request.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  64  write data.
REQ-009 req_wstrb  in  8  byte-lane write strobe.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  64  read data; valid with resp_valid on reads.
REQ-012 resp_err  out  1  rresp/bresp was nonzero.
REQ-013 araddr  out  32, arvalid  out  1, arready  in  1: read-address channel.
REQ-014 rdata  in  64, rresp  in  2, rvalid  in  1, rready  out  1: read-data channel.
REQ-015 awaddr  out  32, awvalid  out  1, awready  in  1: write-address channel.
REQ-016 wdata  out  64, wstrb  out  8, wvalid  out  1, wready  in  1: write-data channel.
REQ-017 bresp  in  2, bvalid  in  1, bready  out  1: write-response channel.

Function
REQ-018 States: IDLE, AR, R, AW_W, B, RESP; all outputs are driven from registers or from state decode only, with no combinational path from AXI inputs.
REQ-019 req_ready is 1 only in IDLE; a request is accepted at a rising edge with req_valid&req_ready, and addr/wdata/wstrb/we are latched at that edge.
REQ-020 Accept with req_we=0 -> AR; accept with req_we=1 -> AW_W; IDLE without req_valid stays IDLE.
REQ-021 AR: arvalid=1 and araddr=latched address; arvalid and araddr stay stable until the arvalid&arready edge, then state -> R.
REQ-022 R: rready=1; at the rvalid&rready edge, capture rdata into resp_rdata, set resp_err=(rresp!=0), state -> RESP.
REQ-023 AW_W: awvalid and wvalid assert together in the first AW_W cycle; each deasserts independently after its own handshake edge (aw_done/w_done flags); both may complete in the same cycle.
REQ-024 awaddr/wdata/wstrb hold latched values throughout AW_W; once aw_done&w_done hold (including same-edge completion), state -> B.
REQ-025 B: bready=1; at the bvalid&bready edge, set resp_err=(bresp!=0), state -> RESP; resp_rdata is unchanged on writes.
REQ-026 RESP: resp_valid=1 for exactly one cycle, then state -> IDLE; there is no backpressure on the response.
REQ-027 Minimum latency with a zero-wait slave: read accept edge N, arvalid in cycle N+1, rready in cycle N+2, resp_valid in cycle N+3; write accept edge N, resp_valid in cycle N+3.
REQ-028 Error responses (2'b10, 2'b11, 2'b01) do not abort the sequence: data is still captured and the normal path to RESP is followed.
REQ-029 Spurious rvalid outside R or bvalid outside B is ignored and causes no state change.
REQ-030 Only one transaction is outstanding at a time; a new request is never accepted before RESP completes.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, arvalid=awvalid=wvalid=rready=bready=0, resp_valid=0, resp_err=0, resp_rdata=0, araddr=awaddr=0, wdata=0, wstrb=0, aw_done=w_done=0.
REQ-032 Reset asserted mid-transaction drops all valid/ready outputs in the same cycle; after release the block is in IDLE with req_ready=1 and issues no residual AXI activity.

Verification
REQ-033 Read, zero-wait slave returning rdata=64'h1122334455667788 with rresp=0 for addr 32'h80000000 -> araddr=80000000, resp_valid exactly at cycle N+3, resp_rdata=1122334455667788, resp_err=0.
REQ-034 Write addr 32'h80000010, wdata=64'hDEADBEEF, wstrb=8'h0F; slave gives awready 2 cycles before wready -> awvalid drops after its handshake, wvalid stays high until its own handshake, exactly one B, resp_err=0.
REQ-035 Read with arready delayed 3 cycles and rvalid delayed 2 cycles -> araddr stable across all arvalid cycles, single resp_valid pulse, req_ready=0 throughout.
REQ-036 Write with bresp=2'b10 and read with rresp=2'b11 -> resp_err=1 on each response, block returns to IDLE.
REQ-037 rst pulsed while in R with rready=1 -> rready=0 immediately, state IDLE, no resp_valid; next read completes normally.
REQ-038 Back-to-back reads with req_valid held high -> second accept occurs the cycle after RESP, no overlap of AR handshakes.
